// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    localparam int FETCH_DEPTH = 2;
    localparam int INSTR_W     = 32;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr} pairs between fetch and decode.
// Entry 0 is always the head; empty slots are kept at zero so the head reads 0 when empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH+INSTR_W-1:0]   push_data_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    output logic [1:0]                 count_o,
    output logic [WIDTH+INSTR_W-1:0]   head_o
);

    localparam int EW = WIDTH + INSTR_W;

    logic [EW-1:0] e0_q, e0_d;
    logic [EW-1:0] e1_q, e1_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          do_pop;
    logic          do_push;

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q;
        do_pop  = pop_i && (cnt_q != 2'd0);
        do_push = push_i && ((cnt_q < 2'(FETCH_DEPTH)) || do_pop);

        if (clear_i) begin
            e0_d  = '0;
            e1_d  = '0;
            cnt_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_d = push_data_i;
                    else               e1_d = push_data_i;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_d  = e1_q;
                    e1_d  = '0;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        e0_d = push_data_i;
                    end else begin
                        e0_d = e1_q;
                        e1_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = e0_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues the PC to instruction memory, waits for the response and
// queues {pc, instr} toward decode; pc_stall gates the PC so it advances once per accepted request.
//
// state | meaning
// IDLE  | first cycle out of reset, no request yet
// REQ   | presenting pc to memory while the queue has room
// WAIT  | one request outstanding, response will be queued
// DROP  | one request outstanding, response discarded (redirected)
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   pc,
    output logic               pc_stall,
    input  logic               redirect,
    output logic               imem_req_valid,
    output logic [WIDTH-1:0]   imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [31:0]        imem_rsp_data,
    output logic               if_valid,
    output logic [31:0]        if_instr,
    output logic [WIDTH-1:0]   if_pc,
    input  logic               if_ready
);

    fetch_state_t state_q, state_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;

    logic                     accept;
    logic                     push;
    logic                     pop;
    logic [1:0]               q_count;
    logic [WIDTH+INSTR_W-1:0] q_head;

    always_comb begin
        state_d        = state_q;
        pend_pc_d      = pend_pc_q;
        push           = 1'b0;
        imem_req_valid = (state_q == ST_REQ) && !redirect && (q_count < 2'(DEPTH));
        accept         = imem_req_valid && imem_req_ready;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (accept) begin
                    pend_pc_d = pc;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response that lands together with a redirect belongs to the old path.
                if (imem_rsp_valid) begin
                    push    = !redirect;
                    state_d = ST_REQ;
                end else if (redirect) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid) state_d = ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase

        pc_stall = !(redirect || accept);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign pop = if_valid && if_ready;

    fetch_queue #(.WIDTH(WIDTH)) u_queue (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i ({pend_pc_q, imem_rsp_data}),
        .pop_i       (pop),
        .clear_i     (redirect),
        .count_o     (q_count),
        .head_o      (q_head)
    );

    assign imem_req_addr = pc;
    assign if_valid      = (q_count != 2'd0);
    assign if_pc         = q_head[WIDTH+INSTR_W-1:INSTR_W];
    assign if_instr      = q_head[INSTR_W-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: acts as PC register, memory and decode, and checks every
// cycle against a queue-level model of what decode should see.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_stall;
    logic        redirect;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    instr_fetch_unit #(.WIDTH(32), .DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .pc_stall       (pc_stall),
        .redirect       (redirect),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    int vectors = 0;
    int miscompares = 0;

    // reference model: what decode should see, plus the single outstanding fetch
    item_t       exp_q[$];
    logic [31:0] popped[$];
    bit          mem_busy;
    bit          mem_drop;
    int          mem_cnt;
    logic [31:0] mem_addr;
    bit          started;

    // knobs: 0 = drive low, 1 = drive high, 2 = random
    int          rr_mode;
    int          ifr_mode;
    int          lat_min;
    int          lat_max;
    int          redir_pct;
    bit          redir_req;
    logic [31:0] redir_tgt;

    logic        obs_req_valid, obs_pc_stall, obs_if_valid;
    logic [31:0] obs_addr, obs_if_pc;

    task automatic reset_model();
        exp_q.delete();
        mem_busy  = 1'b0;
        mem_drop  = 1'b0;
        mem_cnt   = 0;
        mem_addr  = '0;
        pc        = '0;
        started   = 1'b0;
        redir_req = 1'b0;
    endtask

    task automatic step();
        bit          exp_rv, exp_stall, rsp, acc, pop;
        logic [31:0] pc_nxt;
        item_t       it;

        rsp            = mem_busy && (mem_cnt == 1);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? $urandom : 32'h0;
        if (redir_pct > 0 && $urandom_range(0, 99) < redir_pct) begin
            redir_req = 1'b1;
            redir_tgt = $urandom & 32'hFFFF_FFFC;
        end
        redirect       = redir_req;
        imem_req_ready = (rr_mode == 2) ? 1'($urandom_range(0, 1)) : (rr_mode == 1);
        if_ready       = (ifr_mode == 2) ? 1'($urandom_range(0, 1)) : (ifr_mode == 1);
        #1;
        obs_req_valid = imem_req_valid;
        obs_pc_stall  = pc_stall;
        obs_if_valid  = if_valid;
        obs_addr      = imem_req_addr;
        obs_if_pc     = if_pc;

        exp_rv    = started && !mem_busy && !redirect && (exp_q.size() < 2);
        exp_stall = !(redirect || (exp_rv && imem_req_ready));

        vectors++;
        if (imem_req_valid !== exp_rv) begin
            miscompares++;
            $display("FAIL req_valid t=%0t: got %b want %b", $time, imem_req_valid, exp_rv);
        end
        vectors++;
        if (imem_req_addr !== pc) begin
            miscompares++;
            $display("FAIL req_addr t=%0t: got %h want %h", $time, imem_req_addr, pc);
        end
        vectors++;
        if (pc_stall !== exp_stall) begin
            miscompares++;
            $display("FAIL pc_stall t=%0t: got %b want %b", $time, pc_stall, exp_stall);
        end
        vectors++;
        if (if_valid !== (exp_q.size() != 0)) begin
            miscompares++;
            $display("FAIL if_valid t=%0t: got %b want %b", $time, if_valid, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
            it = exp_q[0];
        end else begin
            it.pc    = 32'h0;
            it.instr = 32'h0;
        end
        vectors++;
        if (if_pc !== it.pc || if_instr !== it.instr) begin
            miscompares++;
            $display("FAIL head t=%0t: got pc %h instr %h want pc %h instr %h",
                     $time, if_pc, if_instr, it.pc, it.instr);
        end

        acc = imem_req_valid && imem_req_ready;
        pop = if_valid && if_ready && !redirect;
        if (redirect) begin
            exp_q.delete();
            if (mem_busy) mem_drop = 1'b1;
        end else begin
            if (pop && exp_q.size() != 0) begin
                popped.push_back(exp_q[0].pc);
                void'(exp_q.pop_front());
            end
            if (rsp && !mem_drop) begin
                it.pc    = mem_addr;
                it.instr = imem_rsp_data;
                exp_q.push_back(it);
            end
        end
        pc_nxt = redirect ? redir_tgt : (!pc_stall ? pc + 32'd4 : pc);

        @(posedge clk);
        #1;
        if (rsp) begin
            mem_busy = 1'b0;
            mem_drop = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
        end
        if (acc) begin
            mem_busy = 1'b1;
            mem_drop = 1'b0;
            mem_cnt  = $urandom_range(lat_min, lat_max);
            mem_addr = pc;
        end
        pc        = pc_nxt;
        started   = 1'b1;
        redir_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_pop(input int n, input int budget, input string what);
        int i;
        i = 0;
        while (popped.size() < n && i < budget) begin
            step();
            i++;
        end
        vectors++;
        if (popped.size() < n) begin
            miscompares++;
            $display("FAIL %s timeout: got %0d pops want %0d", what, popped.size(), n);
        end
    endtask

    task automatic drain();
        rr_mode  = 0;
        ifr_mode = 1;
        redir_pct = 0;
        repeat (6) step();
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redir_req = 1'b1;
        redir_tgt = tgt;
        step();
    endtask

    task automatic test_reset();
        int          first;
        logic [31:0] first_pc;
        reset = 1'b0;
        redirect = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = '0; if_ready = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (imem_req_valid !== 1'b0 || pc_stall !== 1'b1 || if_valid !== 1'b0 ||
            if_instr !== 32'h0 || if_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rv=%b stall=%b v=%b instr=%h pc=%h want 0 1 0 0 0",
                     imem_req_valid, pc_stall, if_valid, if_instr, if_pc);
        end
        reset = 1'b1;
        rr_mode = 1; ifr_mode = 1; lat_min = 1; lat_max = 1; redir_pct = 0;
        popped.delete();
        first = -1;
        first_pc = '0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (obs_if_valid && first < 0) begin
                first    = i;
                first_pc = obs_if_pc;
            end
        end
        vectors++;
        if (first !== 4 || first_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL first_valid: got cycle %0d pc %h want cycle 4 pc 0", first, first_pc);
        end
        vectors++;
        if (popped.size() < 3 || popped[0] !== 32'h0 || popped[1] !== 32'h4 || popped[2] !== 32'h8) begin
            miscompares++;
            $display("FAIL pc_sequence: got %0d pops want 0,4,8", popped.size());
        end
    endtask

    task automatic test_req_ready_low();
        drain();
        do_redirect(32'h10);
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (obs_req_valid !== 1'b1 || obs_pc_stall !== 1'b1 || obs_addr !== 32'h10) begin
                miscompares++;
                $display("FAIL ready_low_hold: got rv=%b stall=%b addr=%h want 1 1 00000010",
                         obs_req_valid, obs_pc_stall, obs_addr);
            end
        end
        rr_mode = 1;
        step();
        vectors++;
        if (obs_req_valid !== 1'b1 || obs_pc_stall !== 1'b0 || obs_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL ready_low_accept: got rv=%b stall=%b addr=%h want 1 0 00000010",
                     obs_req_valid, obs_pc_stall, obs_addr);
        end
    endtask

    task automatic test_queue_full();
        drain();
        do_redirect(32'h20);
        ifr_mode = 0; rr_mode = 1; lat_min = 1; lat_max = 1;
        repeat (4) step();
        step();
        vectors++;
        if (obs_req_valid !== 1'b0 || obs_pc_stall !== 1'b1 || obs_if_pc !== 32'h20) begin
            miscompares++;
            $display("FAIL full_hold: got rv=%b stall=%b head=%h want 0 1 00000020",
                     obs_req_valid, obs_pc_stall, obs_if_pc);
        end
        step();
        vectors++;
        if (pc !== 32'h28) begin
            miscompares++;
            $display("FAIL full_pc_held: got %h want 00000028", pc);
        end
        popped.delete();
        ifr_mode = 1;
        step();
        vectors++;
        if (popped.size() != 1 || popped[0] !== 32'h20) begin
            miscompares++;
            $display("FAIL full_pop: got %0d pops want one of 00000020", popped.size());
        end
        ifr_mode = 0;
        step();
        vectors++;
        if (obs_req_valid !== 1'b1 || obs_addr !== 32'h28) begin
            miscompares++;
            $display("FAIL full_next_req: got rv=%b addr=%h want 1 00000028", obs_req_valid, obs_addr);
        end
    endtask

    task automatic test_redirect_wait();
        drain();
        do_redirect(32'h40);
        rr_mode = 1; lat_min = 3; lat_max = 3;
        step();
        lat_min = 1; lat_max = 1;
        popped.delete();
        do_redirect(32'h100);
        step();
        vectors++;
        if (obs_if_valid !== 1'b0 || obs_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_state: got v=%b rv=%b want 0 0", obs_if_valid, obs_req_valid);
        end
        step();
        step();
        vectors++;
        if (obs_req_valid !== 1'b1 || obs_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL drop_next_req: got rv=%b addr=%h want 1 00000100", obs_req_valid, obs_addr);
        end
        wait_pop(1, 10, "drop_first_pop");
        vectors++;
        if (popped.size() == 0 || popped[0] !== 32'h100) begin
            miscompares++;
            $display("FAIL drop_first_pc: got %h want 00000100", popped.size() ? popped[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_with_rsp();
        drain();
        do_redirect(32'h180);
        rr_mode = 1; lat_min = 1; lat_max = 1;
        step();
        do_redirect(32'h200);
        vectors++;
        if (obs_pc_stall !== 1'b0 || obs_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rsp_redirect: got stall=%b rv=%b want 0 0", obs_pc_stall, obs_req_valid);
        end
        step();
        vectors++;
        if (obs_req_valid !== 1'b1 || obs_addr !== 32'h200 || obs_if_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rsp_redirect_after: got rv=%b addr=%h v=%b want 1 00000200 0",
                     obs_req_valid, obs_addr, obs_if_valid);
        end
    endtask

    task automatic test_async_reset();
        drain();
        do_redirect(32'h300);
        ifr_mode = 0; rr_mode = 1; lat_min = 1; lat_max = 1;
        step();
        step();
        lat_min = 3; lat_max = 3;
        step();
        #2;
        reset = 1'b0;
        reset_model();
        #1;
        vectors++;
        if (imem_req_valid !== 1'b0 || pc_stall !== 1'b1 || if_valid !== 1'b0 ||
            if_instr !== 32'h0 || if_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset: got rv=%b stall=%b v=%b instr=%h pc=%h want 0 1 0 0 0",
                     imem_req_valid, pc_stall, if_valid, if_instr, if_pc);
        end
        @(negedge clk);
        reset = 1'b1;
        rr_mode = 1; ifr_mode = 1; lat_min = 1; lat_max = 1;
        popped.delete();
        wait_pop(1, 10, "restart_pop");
        vectors++;
        if (popped.size() == 0 || popped[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL restart_pc: got %h want 00000000", popped.size() ? popped[0] : 32'hx);
        end
    endtask

    task automatic test_random();
        rr_mode = 2; ifr_mode = 2; lat_min = 1; lat_max = 3; redir_pct = 8;
        repeat (600) step();
        redir_pct = 0;
        drain();
    endtask

    initial begin
        test_reset();
        test_req_ready_low();
        test_queue_full();
        test_redirect_wait();
        test_redirect_with_rsp();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
